// File: rtl/seg7_scan_ctrl_if.sv
// Display bus for seg7_scan_ctrl: hex sources and display options in,
// digit selects, segment lines and scan index out.
interface seg7_scan_ctrl_if #(
   parameter int NDIG = 6
);
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

   logic                src_sel;
   logic [4*NDIG-1:0]   dat_a;
   logic [4*NDIG-1:0]   dat_b;
   logic [NDIG-1:0]     dp_in;
   logic                blank_lz;
   logic [NDIG-1:0]     blink_en;
   logic [NDIG-1:0]     dig;
   logic [7:0]          seg;
   logic [IW-1:0]       dig_idx;

   modport master (
      output src_sel, dat_a, dat_b, dp_in, blank_lz, blink_en,
      input  dig, seg, dig_idx
   );

   modport slave (
      input  src_sel, dat_a, dat_b, dp_in, blank_lz, blink_en,
      output dig, seg, dig_idx
   );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed NDIG-digit 7-segment scanner with frame-coherent snapshots,
// leading-zero blanking, per-digit blink and anti-ghost dead time.
module seg7_scan_ctrl #(
   parameter int NDIG        = 6,
   parameter int TICK_DIV    = 25000,
   parameter int DEAD_CYC    = 64,
   parameter int BLINK_TICKS = 500,
   parameter int DIG_ACT_LOW = 1,
   parameter int SEG_ACT_LOW = 1
) (
   input logic              clk50M,
   input logic              rst,
   seg7_scan_ctrl_if.slave  bus
);
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int CW = $clog2(TICK_DIV);
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam int DN = 1 << IW;
   localparam logic DL = (DIG_ACT_LOW != 0);
   localparam logic SL = (SEG_ACT_LOW != 0);

   logic [CW-1:0]      cnt;
   logic [IW-1:0]      idx;
   logic [BW-1:0]      bcnt;
   logic               bph;
   logic               rst_q;
   logic [4*NDIG-1:0]  snap_d;
   logic [NDIG-1:0]    snap_dp;
   logic               snap_lz;
   logic [NDIG-1:0]    snap_bl;
   logic [NDIG-1:0]    dig_q;
   logic [7:0]         seg_q;

   logic               tick;
   logic               last;
   logic               bwrap;
   logic               fs;
   logic               dead;
   logic [4*DN-1:0]    dpad;
   logic [DN-1:0]      dpv;
   logic [DN-1:0]      blv;
   logic [DN-1:0]      zab;
   logic [3:0]         nib;
   logic               lz;
   logic               bk;
   logic [NDIG-1:0]    dig_n;
   logic [7:0]         seg_n;

   function automatic logic [6:0] font(input logic [3:0] n);
      unique case (n)
         4'h0: font = 7'h7E;
         4'h1: font = 7'h30;
         4'h2: font = 7'h6D;
         4'h3: font = 7'h79;
         4'h4: font = 7'h33;
         4'h5: font = 7'h5B;
         4'h6: font = 7'h5F;
         4'h7: font = 7'h70;
         4'h8: font = 7'h7F;
         4'h9: font = 7'h7B;
         4'hA: font = 7'h77;
         4'hB: font = 7'h1F;
         4'hC: font = 7'h4E;
         4'hD: font = 7'h3D;
         4'hE: font = 7'h4F;
         4'hF: font = 7'h47;
      endcase
   endfunction

   assign tick  = (cnt == CW'(TICK_DIV - 1));
   assign last  = (idx == IW'(NDIG - 1));
   assign bwrap = (bcnt == BW'(BLINK_TICKS - 1));
   assign fs    = (rst_q && !rst) || (tick && last);

   generate
      if (DEAD_CYC == 0) begin : g_nodead
         assign dead = 1'b0;
      end else begin : g_dead
         assign dead = (cnt < CW'(DEAD_CYC));
      end
   endgenerate

   // Pad the snapshot to a power-of-two digit count so idx never indexes out of range
   assign dpad = (4*DN)'(snap_d);
   assign dpv  = DN'(snap_dp);
   assign blv  = DN'(snap_bl);
   assign nib  = dpad[{idx, 2'b00} +: 4];

   always_comb begin
      logic acc;
      acc = 1'b1;
      zab = '0;
      for (int i = DN - 1; i >= 0; i--) begin
         acc    = acc & (dpad[4*i +: 4] == 4'h0);
         zab[i] = acc;
      end
   end

   assign lz = snap_lz && (idx != '0) && zab[idx];
   assign bk = bph && blv[idx];

   always_comb begin
      dig_n = dead ? '0 : (NDIG'(1) << idx);
      seg_n = {font(nib), dpv[idx]};
      if (bk) begin
         seg_n = 8'h00;
      end else if (lz) begin
         seg_n = {7'h00, dpv[idx]};
      end
   end

   always_ff @(posedge clk50M) begin
      rst_q <= rst;
      if (rst) begin
         cnt     <= '0;
         idx     <= '0;
         bcnt    <= '0;
         bph     <= 1'b0;
         snap_d  <= '0;
         snap_dp <= '0;
         snap_lz <= 1'b0;
         snap_bl <= '0;
         dig_q   <= {NDIG{DL}};
         seg_q   <= {8{SL}};
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick) begin
            idx <= last ? '0 : idx + 1'b1;
            if (bwrap) begin
               bcnt <= '0;
               bph  <= ~bph;
            end else begin
               bcnt <= bcnt + 1'b1;
            end
         end
         if (fs) begin
            snap_d  <= bus.src_sel ? bus.dat_b : bus.dat_a;
            snap_dp <= bus.dp_in;
            snap_lz <= bus.blank_lz;
            snap_bl <= bus.blink_en;
         end
         dig_q <= dig_n ^ {NDIG{DL}};
         seg_q <= seg_n ^ {8{SL}};
      end
   end

   assign bus.dig     = dig_q;
   assign bus.seg     = seg_q;
   assign bus.dig_idx = idx;
endmodule
